// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for a unified instruction/data memory with burst-limited tenures.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break from IDLE instead of fixed master-0 priority.
module mem_arbiter #(
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] adr0,
    input  logic [31:0] wd0,
    output logic [31:0] rd0,
    output logic        gnt0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] adr1,
    input  logic [31:0] wd1,
    output logic [31:0] rd1,
    output logic        gnt1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       last_owner, last_n;
    logic       own_req, oth_req, pick1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_owner <= last_n;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign pick1 = req1 & (~req0 | ~last_owner);
`else
    assign pick1 = req1 & ~req0;
`endif

    assign own_req = (state == OWN1) ? req1 : req0;
    assign oth_req = (state == OWN1) ? req0 : req1;

    // Tenure ends on a dropped request or on the last allowed beat with the other master waiting.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last_owner;
        if (state == IDLE) begin
            cnt_n   = '0;
            state_n = pick1 ? OWN1 : (req0 ? OWN0 : IDLE);
        end else if (own_req && cnt != 8'(BURST_MAX - 1)) begin
            cnt_n = cnt + 8'd1;
        end else begin
            cnt_n = '0;
            if (oth_req)
                state_n = (state == OWN1) ? OWN0 : OWN1;
            else if (!own_req)
                state_n = IDLE;
            if (oth_req || !own_req)
                last_n = (state == OWN1);
        end
    end

    assign gnt0   = (state == OWN0);
    assign gnt1   = (state == OWN1);
    assign mem_a  = gnt0 ? adr0 : (gnt1 ? adr1 : '0);
    assign mem_wd = gnt0 ? wd0 : (gnt1 ? wd1 : '0);
    assign mem_we = gnt0 ? (we0 & req0) : (gnt1 ? (we1 & req1) : 1'b0);
    assign rd0    = gnt0 ? mem_rd : '0;
    assign rd1    = gnt1 ? mem_rd : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus hand sequences for mem_arbiter, checked through an expectation queue.
// A second instance with BURST_MAX=1 is checked for per-cycle alternation under contention.
module tb_mem_arbiter;
    typedef struct packed {
        logic        g0, g1, we;
        logic [31:0] a, wd, r0, r1;
    } out_t;

    typedef struct {
        logic        q0, w0;
        logic [31:0] a0, d0;
        logic        q1, w1;
        logic [31:0] a1, d1;
        out_t        e;
    } vec_t;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, mem_init = 1'b1;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wd0, adr1, wd1;
    logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;
    logic        gnt0, gnt1, mem_we;
    logic [31:0] rd0_b, rd1_b, mem_a_b, mem_wd_b;
    logic        gnt0_b, gnt1_b, mem_we_b;
    logic [31:0] mem [256];
    out_t        sb[$];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        else if (mem_we)
            mem[mem_a[9:2]] <= mem_wd;
    end

    mem_arbiter #(.BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .rd0(rd0), .gnt0(gnt0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .rd1(rd1), .gnt1(gnt1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_arbiter #(.BURST_MAX(1)) dut1 (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .rd0(rd0_b), .gnt0(gnt0_b),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .rd1(rd1_b), .gnt1(gnt1_b),
        .mem_we(mem_we_b), .mem_a(mem_a_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd)
    );

    task automatic drive(input logic q0, w0, input logic [31:0] a0, d0,
                         input logic q1, w1, input logic [31:0] a1, d1);
        req0 = q0; we0 = w0; adr0 = a0; wd0 = d0;
        req1 = q1; we1 = w1; adr1 = a1; wd1 = d1;
    endtask

    task automatic check(input string name);
        out_t e, got;
        got = '{gnt0, gnt1, mem_we, mem_a, mem_wd, rd0, rd1};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got g0=%b g1=%b we=%b a=%h wd=%h rd0=%h rd1=%h, want g0=%b g1=%b we=%b a=%h wd=%h rd0=%h rd1=%h",
                         name, got.g0, got.g1, got.we, got.a, got.wd, got.r0, got.r1,
                         e.g0, e.g1, e.we, e.a, e.wd, e.r0, e.r1);
            end
        end
    endtask

    // Called at posedge+1: queue the expectation, compare mid-cycle, advance one clock.
    task automatic step(input out_t e, input string name);
        sb.push_back(e);
        #2 check(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input logic e0, e1, input string name);
        checks++;
        if ({gnt0_b, gnt1_b} !== {e0, e1}) begin
            errors++;
            $display("FAIL %s: got gnt0=%b gnt1=%b, want gnt0=%b gnt1=%b", name, gnt0_b, gnt1_b, e0, e1);
        end
    endtask

    initial begin
        vec_t vt[10];
        out_t z, o0, o1, ow;
        bit   f;
        int   n;
        z  = '0;
        o0 = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'hA500_0008, 32'h0};
        o1 = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'hDEAD_BEEF};
        vt[0] = '{1'b1, 1'b0, 32'h20, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0, z};
        vt[1] = '{1'b1, 1'b0, 32'h20, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0,
                  '{1'b1, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 32'hA500_0008, 32'h0}};
        vt[2] = '{1'b0, 1'b0, 32'h20, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0,
                  '{1'b1, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 32'hA500_0008, 32'h0}};
        vt[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, z};
        vt[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF,
                  '{1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 32'hA500_0010}};
        vt[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF,
                  '{1'b0, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF}};
        vt[6] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, z};
        vt[7] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 32'h0}};
        vt[8] = '{1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 32'h0}};
        vt[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, z};
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with random requests: everything decodes to zero.
        repeat (4) begin
            @(posedge clk);
            #1 drive($urandom_range(0, 1) == 1, 1'b1, $urandom, $urandom,
                     $urandom_range(0, 1) == 1, 1'b1, $urandom, $urandom);
            sb.push_back(z);
            #1 check("reset_hold");
        end
        reset = 1'b0;
        mem_init = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].q0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].q1, vt[i].w1, vt[i].a1, vt[i].d1);
            step(vt[i].e, $sformatf("vec%0d", i));
        end

        // Simultaneous requests from IDLE after a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 drive(1, 0, 32'h20, 0, 1, 0, 32'h40, 0);
        step(z, "t4_idle");
        step(o0, "t4_first");
        drive(0, 0, 32'h20, 0, 0, 0, 32'h40, 0);
        step(o0, "t4_drop");
        drive(1, 0, 32'h20, 0, 1, 0, 32'h40, 0);
        step(z, "t4_idle2");

        // Both held: tenures of BURST_MAX beats with no gap; the BURST_MAX=1 copy alternates each cycle.
        f = RR;
        for (int i = 0; i < 32; i++) begin
            ow = (f ^ ((i / 8) % 2 == 1)) ? o1 : o0;
            #1 check_b(f ^ (i % 2 == 1) ? 1'b0 : 1'b1, f ^ (i % 2 == 1) ? 1'b1 : 1'b0, $sformatf("b1_alt%0d", i));
            #0 sb.push_back(ow);
            #1 check($sformatf("burst%0d", i));
            @(posedge clk);
            #1;
        end
        drive(0, 0, 32'h20, 0, 0, 0, 32'h40, 0);
        step(f ? o1 : o0, "t3_drop");

        // Master 1 alone for 20 cycles keeps its grant through counter wraps.
        drive(0, 0, 32'h20, 0, 1, 0, 32'h40, 0);
        step(z, "t5_idle");
        for (int i = 0; i < 20; i++) step(o1, $sformatf("t5_hold%0d", i));
        drive(0, 0, 32'h20, 0, 0, 0, 32'h40, 0);
        step(o1, "t5_drop");
        step(z, "t5_after");

        // Reset in the middle of a granted write cycle.
        drive(1, 1, 32'h80, 32'h1234_5678, 0, 0, 0, 0);
        n = 0;
        while (!gnt0 && n < 4) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (!gnt0) begin
            errors++;
            $display("FAIL t6_grant: gnt0=%b after %0d cycles, want 1", gnt0, n);
        end
        #1 checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL t6_we: mem_we=%b, want 1", mem_we);
        end
        #1 reset = 1'b1;
        #1 checks++;
        if ({gnt0, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL t6_async: gnt0=%b mem_we=%b, want 0 0", gnt0, mem_we);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1, 0, 32'h80, 0, 0, 0, 0, 0);
        step(z, "t6_idle");
        step('{1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'hA500_0020, 32'h0}, "t6_no_commit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
